// File: rtl/btn_conditioner.sv
// Six-channel switch conditioner: 2-flop sync, counter debounce, rising-edge press pulse.
// Optional status outputs (level, chatter) are built only with BTN_COND_STATUS_EN defined.
module btn_conditioner #(
    parameter int unsigned  DEBOUNCE_CYCLES = 16,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw_btn,
    input  logic       raw_enter,
    input  logic       raw_clear,
    output logic [3:0] btn,
    output logic       enter,
    output logic       clear
`ifdef BTN_COND_STATUS_EN
    ,
    output logic [5:0] level,
    output logic       chatter
`endif
);

    localparam int unsigned      NCH     = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   raw_c;
    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   sync2;
    logic [NCH-1:0]   stable;
    logic [NCH-1:0]   pulse;
    logic [CNT_W-1:0] cnt [NCH];
    logic [NCH-1:0]   differ_c;
    logic [NCH-1:0]   done_c;

    assign raw_c = {raw_clear, raw_enter, raw_btn};

    // Metastability guard: only sync2 is consumed downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_c;
            sync2 <= sync1;
        end
    end

    always_comb begin
        differ_c = '0;
        done_c   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            differ_c[i] = sync2[i] ^ stable[i];
            done_c[i]   = differ_c[i] && (cnt[i] == CNT_MAX);
        end
    end

    // A sample matching the stable level aborts any count in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            pulse  <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!differ_c[i] || done_c[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            stable <= stable ^ done_c;
            pulse  <= done_c & sync2;
        end
    end

    assign btn   = pulse[3:0];
    assign enter = pulse[4];
    assign clear = pulse[5];

`ifdef BTN_COND_STATUS_EN
    logic [NCH-1:0] abort_c;

    always_comb begin
        abort_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            abort_c[i] = !differ_c[i] && (cnt[i] != '0);
        end
    end

    // Sticky bounce flag, acknowledged by a clear press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chatter <= 1'b0;
        end else if (pulse[5]) begin
            chatter <= 1'b0;
        end else if (|abort_c) begin
            chatter <= 1'b1;
        end
    end

    assign level = stable;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4.
// Status outputs are checked only when BTN_COND_STATUS_EN is defined.
module tb_btn_conditioner;

    localparam int D = 4;

    typedef struct {
        int         cyc;
        logic [5:0] mask;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] raw_btn;
    logic       raw_enter;
    logic       raw_clear;
    logic [3:0] btn;
    logic       enter;
    logic       clear;
`ifdef BTN_COND_STATUS_EN
    logic [5:0] level;
    logic       chatter;
`endif

    int   cyc;
    int   pass_cnt;
    int   total_cnt;
    exp_t exp_q[$];

    btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_btn   (raw_btn),
        .raw_enter (raw_enter),
        .raw_clear (raw_clear),
        .btn       (btn),
        .enter     (enter),
        .clear     (clear)
`ifdef BTN_COND_STATUS_EN
        ,
        .level     (level),
        .chatter   (chatter)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Every nonzero pulse vector must match the oldest expected press
    always @(negedge clk) begin
        logic [5:0] obs;
        exp_t       e;
        obs = {clear, enter, btn};
        if (obs !== 6'd0) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got %b at cycle %0d, required none", obs, cyc);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e.mask || cyc != e.cyc)
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                             obs, cyc, e.mask, e.cyc);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press whose first sample lands on the next posedge
    task automatic expect_press(input logic [5:0] m);
        exp_q.push_back('{cyc: cyc + D + 2, mask: m});
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        raw_btn   = 4'b1111;
        raw_enter = 1'b0;
        raw_clear = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total_cnt++;
            if ({clear, enter, btn} !== 6'd0)
                $display("FAIL reset_outputs: got %b, required 000000", {clear, enter, btn});
            else
                pass_cnt++;
        end
        reset = 1'b1;
        expect_press(6'b001111);
        @(negedge clk);
        total_cnt++;
        if ({clear, enter, btn} !== 6'd0)
            $display("FAIL post_release: got %b, required 000000", {clear, enter, btn});
        else
            pass_cnt++;
        tick(20);
`ifdef BTN_COND_STATUS_EN
        total_cnt++;
        if (level !== 6'b001111) $display("FAIL reset_level: got %b, required 001111", level);
        else pass_cnt++;
`endif
        raw_btn = 4'b0000;
        tick(20);
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL reset_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_clean_press();
        raw_btn = 4'b0010;
        expect_press(6'b000010);
        tick(20);
`ifdef BTN_COND_STATUS_EN
        total_cnt++;
        if (chatter !== 1'b0) $display("FAIL clean_chatter: got %b, required 0", chatter);
        else pass_cnt++;
`endif
        raw_btn = 4'b0000;
        tick(20);
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL clean_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            raw_enter = (i % 2 == 0);
            tick(1);
        end
        raw_enter = 1'b1;
        expect_press(6'b010000);
        tick(20);
`ifdef BTN_COND_STATUS_EN
        total_cnt++;
        if (chatter !== 1'b1) $display("FAIL bounce_chatter: got %b, required 1", chatter);
        else pass_cnt++;
`endif
        raw_enter = 1'b0;
        tick(20);
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL bounce_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_glitch();
        raw_clear = 1'b1;
        tick(3);
        raw_clear = 1'b0;
        tick(20);
`ifdef BTN_COND_STATUS_EN
        total_cnt++;
        if (level[5] !== 1'b0) $display("FAIL glitch_level: got %b, required 0", level[5]);
        else pass_cnt++;
`endif
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL glitch_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_clear_press();
        raw_clear = 1'b1;
        expect_press(6'b100000);
        tick(12);
`ifdef BTN_COND_STATUS_EN
        total_cnt++;
        if (chatter !== 1'b0) $display("FAIL clear_ack_chatter: got %b, required 0", chatter);
        else pass_cnt++;
`endif
        raw_clear = 1'b0;
        tick(20);
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL clear_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        raw_enter = 1'b1;
        raw_btn   = 4'b0001;
        expect_press(6'b010001);
        tick(20);
        raw_enter = 1'b0;
        raw_btn   = 4'b0000;
        tick(20);
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL simul_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        raw_btn = 4'b0100;
        expect_press(6'b000100);
        tick(10);
        raw_btn = 4'b0000;
        tick(10);
        raw_btn = 4'b0100;
        expect_press(6'b000100);
        tick(10);
        raw_btn = 4'b0000;
        tick(20);
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL b2b_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        raw_enter = 1'b1;
        tick(1);
        raw_enter = 1'b0;
        tick(4);
        raw_btn = 4'b1000;
        tick(4);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total_cnt++;
            if ({clear, enter, btn} !== 6'd0)
                $display("FAIL midreset_outputs: got %b, required 000000", {clear, enter, btn});
            else
                pass_cnt++;
        end
`ifdef BTN_COND_STATUS_EN
        total_cnt++;
        if (chatter !== 1'b0) $display("FAIL midreset_chatter: got %b, required 0", chatter);
        else pass_cnt++;
`endif
        reset = 1'b1;
        expect_press(6'b001000);
        tick(20);
        raw_btn = 4'b0000;
        tick(20);
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL midreset_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    initial begin
        cyc       = 0;
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_clear_press();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage between the raw keypad/enter/clear switches and the lock FSM.
- Each of its 6 channels (btn[3:0], enter, clear) gets a 2-flop synchronizer, a counter debouncer and rising-edge detection.
- Output is a single-cycle press pulse per channel, which the lock FSM consumes directly.
- Channels are fully independent; simultaneous presses pass through unchanged, and the FSM flags them as invalid.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive differing synchronized samples required to accept a new level; legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, do not override.

Ports:
- clk  input  1  system clock, all flops on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- raw_btn  input  4  asynchronous keypad switch levels, 1 = pressed.
- raw_enter  input  1  asynchronous enter switch level.
- raw_clear  input  1  asynchronous clear switch level.
- btn  output  4  per-digit press pulse, 1 cycle wide.
- enter  output  1  enter press pulse, 1 cycle wide.
- clear  output  1  clear press pulse, 1 cycle wide.
- level  output  6  debounced levels {clear, enter, btn[3:0]}; present only with BTN_COND_STATUS_EN.
- chatter  output  1  sticky bounce-detected flag; present only with BTN_COND_STATUS_EN.

Behaviour:
- Reset (reset=0, asynchronous): all sync flops, stable levels, counters and pulse outputs go to 0.
  - Outputs are 0 while reset is low and in the first cycle after release.
- Synchronizer: sync1 <= raw; sync2 <= sync1. Only sync2 is used downstream.
- Debounce, per channel, at each edge:
  - sync2 == stable: cnt <= 0 (an aborted bounce resets the count).
  - sync2 != stable and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
- Pulse: pulse is a registered output, set to 1 on the same edge where stable goes 0->1, and 0 on every other edge.
  - Falling transitions produce no pulse.
- Latency: raw=1 first sampled at edge k -> pulse high for exactly the cycle after edge k+DEBOUNCE_CYCLES+1.
  - Example, DEBOUNCE_CYCLES=4: raw sampled at edge 0 -> pulse high between edges 5 and 6.
- Pulse rate: a held press yields exactly one pulse. A new pulse requires a debounced release (DEBOUNCE_CYCLES stable-low samples) and then a debounced press.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse and no change to stable.
- Simultaneous presses: channels whose debounce completes on the same edge all pulse on the same cycle. There is no arbitration or masking.
- Reset mid-operation: counts and levels are discarded.
  - A switch still held at reset release is treated as a fresh press and pulses after the full latency.
- Counter is never allowed to exceed DEBOUNCE_CYCLES-1; no wrap-around.

Optional Feature:
- Macro: BTN_COND_STATUS_EN.
- Defined: level and chatter ports exist.
  - level = the 6 stable registers.
  - chatter sets (sticky) on any edge where a channel has cnt != 0 and sync2 == stable, i.e. an aborted transition.
  - chatter clears only on reset or on a cycle where the clear output pulses.
  - chatter reset value is 0.
- Undefined: level and chatter ports, plus their logic, are absent. Pulse behaviour is identical in both builds.

Test Plan:
- Reset + idle: reset=0 for 3 cycles with raw_btn=4'b1111, then release -> all outputs 0 during reset. btn=4'b1111 pulses exactly once, 1 cycle, DEBOUNCE_CYCLES+2 edges after release.
- Clean press, DEBOUNCE_CYCLES=4: raw_btn=4'b0010 sampled at edge 0 and held 20 cycles -> btn=4'b0010 only in the cycle after edge 5, then 0. No pulse on release.
- Bounce: raw_enter toggles 1,0,1,0 on alternate cycles, then held 1 -> no pulse during toggling. enter pulses once, 5 edges after the final stable-high sample begins. chatter=1 (STATUS_EN build).
- Glitch reject: raw_clear high for 3 cycles only (DEBOUNCE_CYCLES=4) -> clear never pulses, level[5] stays 0.
- Simultaneous: raw_enter and raw_btn[0] rise on the same edge -> enter=1 and btn=4'b0001 pulse in the same cycle.
- Mid-debounce reset: raw_btn[3] held; reset pulsed low at cnt=2 -> no pulse before reset. After release, btn[3] pulses after full latency. chatter=0 after reset.
